// File: rtl/mem_bus_pattern_driver_if.sv
// Memory-bus bundle between the pattern driver (master) and a RAM-like target (slave).
// data_in carries the target's registered read data back to the master.
interface mem_bus_pattern_driver_if #(
  parameter int unsigned addr_size = 16,
  parameter int unsigned word_size = 16
);
  logic [addr_size-1:0] addr;
  logic [word_size-1:0] data_out;
  logic [word_size-1:0] data_in;
  logic                 write_en;

  modport master (
    output addr,
    output data_out,
    output write_en,
    input  data_in
  );

  modport slave (
    input  addr,
    input  data_out,
    input  write_en,
    output data_in
  );
endinterface

// File: rtl/mem_bus_pattern_driver.sv
// Writes a packed word pattern into a memory window, reads it back and scores every word.
// Optional macro MEM_DRIVER_STOP_ON_MISMATCH_EN ends the sequence on the first failing compare.
module mem_bus_pattern_driver #(
  parameter int unsigned                     addr_size     = 16,
  parameter int unsigned                     word_size     = 16,
  parameter int unsigned                     array_size    = 2,
  parameter logic [addr_size-1:0]            base_addr     = '0,
  parameter logic [array_size*word_size-1:0] array_content = 32'hFFFFFFFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  mem_bus_pattern_driver_if.master bus,
  output logic                     busy,
  output logic                     done,
  output logic                     readback_ok,
  output logic [addr_size-1:0]     mismatch_count,
  output logic [addr_size-1:0]     first_bad_index
);

  localparam int unsigned idx_w = (array_size > 1) ? $clog2(array_size) : 1;
  localparam logic [idx_w-1:0] last_idx = idx_w'(array_size - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t               state;
  logic [idx_w-1:0]     idx;
  logic [idx_w-1:0]     idx_next;
  logic [addr_size-1:0] addr_q;
  logic [word_size-1:0] wdata_q;
  logic                 we_q;

  // Read-tracking pipeline: stage 0 = read issued, stage 1 = target data arriving next edge.
  logic                 pv0;
  logic                 pv1;
  logic [idx_w-1:0]     pi0;
  logic [idx_w-1:0]     pi1;

  logic                 cmp_bad;
  logic [addr_size-1:0] cnt_next;
  logic [addr_size-1:0] fbi_next;

  function automatic logic [word_size-1:0] word_at(input logic [idx_w-1:0] i);
    return word_size'(array_content >> (int'(i) * word_size));
  endfunction

  function automatic logic [addr_size-1:0] win_addr(input logic [idx_w-1:0] i);
    return base_addr + addr_size'(i);
  endfunction

  assign bus.addr     = addr_q;
  assign bus.data_out = wdata_q;
  assign bus.write_en = we_q;

  assign idx_next = idx + idx_w'(1);

  // Score the read whose data is on data_in this cycle.
  always_comb begin
    cmp_bad  = pv1 && (bus.data_in != word_at(pi1));
    cnt_next = mismatch_count;
    fbi_next = first_bad_index;
    if (cmp_bad) begin
      if (mismatch_count != '1) begin
        cnt_next = mismatch_count + addr_size'(1);
      end
      if (first_bad_index == '1) begin
        fbi_next = addr_size'(pi1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      idx             <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      we_q            <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      readback_ok     <= 1'b0;
      mismatch_count  <= '0;
      first_bad_index <= '1;
      pv0             <= 1'b0;
      pv1             <= 1'b0;
      pi0             <= '0;
      pi1             <= '0;
    end else begin
      pv1             <= pv0;
      pi1             <= pi0;
      pv0             <= 1'b0;
      mismatch_count  <= cnt_next;
      first_bad_index <= fbi_next;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= WRITE;
            idx             <= '0;
            addr_q          <= base_addr;
            wdata_q         <= word_at('0);
            we_q            <= 1'b1;
            busy            <= 1'b1;
            done            <= 1'b0;
            readback_ok     <= 1'b0;
            mismatch_count  <= '0;
            first_bad_index <= '1;
          end
        end

        WRITE: begin
          if (idx == last_idx) begin
            // Last word written: this edge also issues read 0.
            state   <= READ;
            idx     <= '0;
            addr_q  <= base_addr;
            wdata_q <= '0;
            we_q    <= 1'b0;
            pv0     <= 1'b1;
            pi0     <= '0;
          end else begin
            idx     <= idx_next;
            addr_q  <= win_addr(idx_next);
            wdata_q <= word_at(idx_next);
          end
        end

        READ: begin
          if (idx == last_idx) begin
            state  <= DRAIN;
            addr_q <= '0;
          end else begin
            idx    <= idx_next;
            addr_q <= win_addr(idx_next);
            pv0    <= 1'b1;
            pi0    <= idx_next;
          end
        end

        DRAIN: begin
          // The final compare lands on this edge and is folded into readback_ok.
          if (!pv0) begin
            state       <= DONE;
            done        <= 1'b1;
            busy        <= 1'b0;
            readback_ok <= (cnt_next == '0);
          end
        end

        default: state <= IDLE;
      endcase

`ifdef MEM_DRIVER_STOP_ON_MISMATCH_EN
      if (cmp_bad) begin
        state       <= DONE;
        done        <= 1'b1;
        busy        <= 1'b0;
        readback_ok <= 1'b0;
        idx         <= '0;
        addr_q      <= '0;
        wdata_q     <= '0;
        we_q        <= 1'b0;
        pv0         <= 1'b0;
        pv1         <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: doc/mem_bus_pattern_driver.md
Name: mem_bus_pattern_driver

Overview:
Simulation-side bus master that sits directly upstream of a RAM-like memory bus target and drives its addr/data_in/write_en.
- On a start pulse it writes a predefined word pattern into a contiguous address window, then reads the window back and compares each word.
- Reports done, pass/fail, mismatch count and first failing index.
- Acts as a self-checking stimulus source for memory-bus slaves in testbenches.

Parameters:
- base_addr, 0: first bus address of the window.
- addr_size, 16: bus address width.
- word_size, 16: bus data width.
- array_size, 2: number of words written and checked.
- array_content, 32'hFFFFFFFF: packed pattern. Word i = (array_content >> i*word_size) & ((1<<word_size)-1).

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a sequence; sampled only in IDLE or DONE.
- addr  out  addr_size  bus address (registered).
- data_out  out  word_size  write data to the target's data_in (registered).
- data_in  in  word_size  read data from the target's data_out; 1-cycle registered latency on the target side.
- write_en  out  1  bus write strobe (registered).
- busy  out  1  high from the accepted start until done.
- done  out  1  level; held until the next accepted start.
- readback_ok  out  1  valid when done; 1 = zero mismatches.
- mismatch_count  out  addr_size  number of failing compares; saturates at all-ones.
- first_bad_index  out  addr_size  index of the first mismatch; all-ones if none.

Behaviour:
- Reset (asynchronous, immediate): state IDLE. addr=0, data_out=0, write_en=0, busy=0, done=0, readback_ok=0, mismatch_count=0, first_bad_index=all-ones. The compare pipeline is flushed.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE/DONE, start=1 at edge E0:
  - Next state is WRITE.
  - Loads addr=base_addr, data_out=word0, write_en=1, busy=1, done=0.
  - Clears mismatch_count, readback_ok, first_bad_index.
- WRITE:
  - Each edge advances index i; presents addr=base_addr+i, data_out=word i, write_en=1.
  - Word i is on the bus during the cycle after edge E(i).
  - After word array_size-1, the next edge moves to READ with write_en=0, data_out=0, addr=base_addr.
- READ:
  - Read i is issued (addr updated) at edge E(array_size+i), one address per cycle, write_en=0.
  - After the last issue, the next edge moves to DRAIN; addr returns to 0.
- Compare pipeline:
  - A 2-deep valid/index shift register tracks reads.
  - data_in for read i is sampled and compared at edge E(array_size+i+2).
  - On mismatch: mismatch_count increments (saturating). first_bad_index is loaded only if it still equals all-ones.
- DRAIN:
  - Waits for the compare pipeline to empty.
  - The edge that performs the final compare, E(2*array_size+1), also moves to DONE.
  - On that edge: done=1, busy=0, readback_ok=(final mismatch count==0), with the last compare already included.
  - Default parameters: done rises at E5.
- Address arithmetic: base_addr+i truncated to addr_size bits; wraps modulo 2^addr_size.
- start while busy is ignored. A start held high in DONE restarts immediately.
- Reset asserted mid-sequence: write_en drops without waiting for a clock edge; no partial result is reported.
- array_size=1 is legal: write at E0, read issued at E1, compare and done at E3.

Optional Feature:
Macro MEM_DRIVER_STOP_ON_MISMATCH_EN.
- Defined: the first mismatching compare ends the sequence on that edge.
  - State goes to DONE; done=1, busy=0, readback_ok=0, mismatch_count=1.
  - Any in-flight reads are discarded; addr=0, write_en=0.
- Undefined: every word is checked and mismatch_count reports the total.

Test Plan:
- Default params, memory target at base 0; pulse start -> E0/E1 write 16'hFFFF to addr 0 and 1, done=1 at E5, readback_ok=1, mismatch_count=0, first_bad_index=16'hFFFF.
- array_content=32'h1234ABCD -> addr0 gets 16'hABCD, addr1 gets 16'h1234 (write_en=1 exactly 2 cycles), readback_ok=1.
- Force data_in=16'h0000 during read 1 compare only -> mismatch_count=1, first_bad_index=1, readback_ok=0. With MEM_DRIVER_STOP_ON_MISMATCH_EN: done also at E5. Force during read 0 instead -> done at E4.
- Pulse start again at E2 (busy) -> ignored, done still at E5. A second start after done -> outputs cleared and full sequence repeats with identical timing.
- Assert reset between E0 and E1 -> write_en=0 and busy=0 without waiting for an edge; after release, outputs remain at reset values until start.
- addr_size=4, base_addr=15, array_size=2 -> writes go to addr 15 then 0 (wrap), readback_ok=1.
